// File: rtl/adder_control_unit.sv
// -----------------------------------------------------------------------------
// adder_control_unit
//
// Sequencer for the 32-bit adder datapath. Each press of the enter key loads
// one byte of an operand from the board switches, least-significant byte
// first: operand A, then operand B. Every byte is strobed into the peripherals
// unit with a loaddata/inputdata_ready handshake. After the last B byte the
// unit waits for the adder to settle, pulses latch_result and shows the sum.
// A handshake that is never acknowledged parks the unit in an error state
// until the next press.
//
// Ports:
//   clk             in   system clock
//   reset           in   asynchronous active-low reset
//   enter           in   raw enter key (active-high, asynchronous to clk)
//   inputdata_ready in   datapath acknowledge for the current byte
//   loaddata        out  one-cycle strobe: load the selected byte
//   load_a          out  operand A is being collected
//   load_b          out  operand B is being collected
//   byte_sel        out  byte index being loaded (0 = LSB)
//   latch_result    out  one-cycle pulse: capture dataR
//   disp_sel        out  display source: 0 = A, 1 = B, 2 = R, 3 = error
//   busy            out  handshake or settle in progress
//   done            out  result is being shown
//   error           out  acknowledge timeout occurred
//
// All outputs are registered and decoded from the next state, so each one
// follows the state register exactly with no combinational path to a port.
// -----------------------------------------------------------------------------
module adder_control_unit #(
    parameter int BYTES_PER_OPERAND = 4,
    parameter int ACK_TIMEOUT       = 16,
    parameter int SETTLE_CYCLES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic       inputdata_ready,
    output logic       loaddata,
    output logic       load_a,
    output logic       load_b,
    output logic [1:0] byte_sel,
    output logic       latch_result,
    output logic [1:0] disp_sel,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_MAX = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0]       LAST_BYTE = 2'(BYTES_PER_OPERAND - 1);
    // The counter is loaded with 1 as the strobe leaves, so it equals the
    // number of cycles since loaddata; ACK_TIMEOUT-1 is the last ACK cycle.
    localparam logic [CNT_W-1:0] ACK_TC    = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WAIT_A   = 4'd1,
        S_STROBE_A = 4'd2,
        S_ACK_A    = 4'd3,
        S_WAIT_B   = 4'd4,
        S_STROBE_B = 4'd5,
        S_ACK_B    = 4'd6,
        S_SETTLE   = 4'd7,
        S_CALC     = 4'd8,
        S_SHOW     = 4'd9,
        S_ERR      = 4'd10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_byte_sel;
    logic [1:0]       w_byte_sel_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic r_enter_s1;
    logic r_enter_s2;
    logic r_enter_s3;
    logic r_enter_p;

    logic       r_loaddata;
    logic       r_load_a;
    logic       r_load_b;
    logic       r_latch_result;
    logic [1:0] r_disp_sel;
    logic       r_busy;
    logic       r_done;
    logic       r_error;

    logic       w_loaddata_nxt;
    logic       w_load_a_nxt;
    logic       w_load_b_nxt;
    logic       w_latch_result_nxt;
    logic [1:0] w_disp_sel_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_error_nxt;

    // Enter key: two-flop synchronizer, then registered rising-edge detect.
    // A held key yields a single r_enter_p because s3 follows s2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enter_s1 <= 1'b0;
            r_enter_s2 <= 1'b0;
            r_enter_s3 <= 1'b0;
            r_enter_p  <= 1'b0;
        end else begin
            r_enter_s1 <= enter;
            r_enter_s2 <= r_enter_s1;
            r_enter_s3 <= r_enter_s2;
            r_enter_p  <= r_enter_s2 & ~r_enter_s3;
        end
    end

    // Next-state, byte index and shared cycle counter.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_sel_nxt = r_byte_sel;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (r_enter_p) begin
                    w_state_nxt    = S_STROBE_A;
                    w_byte_sel_nxt = 2'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_A: begin
                if (r_enter_p) begin
                    w_state_nxt = S_STROBE_A;
                end else begin
                    w_state_nxt = S_WAIT_A;
                end
            end
            S_STROBE_A: begin
                w_state_nxt = S_ACK_A;
                w_cnt_nxt   = CNT_W'(1);
            end
            S_ACK_A: begin
                // Ready wins over the terminal count on the same cycle.
                if (inputdata_ready) begin
                    if (r_byte_sel == LAST_BYTE) begin
                        w_state_nxt    = S_WAIT_B;
                        w_byte_sel_nxt = 2'd0;
                    end else begin
                        w_state_nxt    = S_WAIT_A;
                        w_byte_sel_nxt = r_byte_sel + 2'd1;
                    end
                end else if (r_cnt >= ACK_TC) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_B: begin
                if (r_enter_p) begin
                    w_state_nxt = S_STROBE_B;
                end else begin
                    w_state_nxt = S_WAIT_B;
                end
            end
            S_STROBE_B: begin
                w_state_nxt = S_ACK_B;
                w_cnt_nxt   = CNT_W'(1);
            end
            S_ACK_B: begin
                if (inputdata_ready) begin
                    if (r_byte_sel == LAST_BYTE) begin
                        w_state_nxt    = S_SETTLE;
                        w_byte_sel_nxt = 2'd0;
                        w_cnt_nxt      = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt    = S_WAIT_B;
                        w_byte_sel_nxt = r_byte_sel + 2'd1;
                    end
                end else if (r_cnt >= ACK_TC) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (r_cnt >= SETTLE_TC) begin
                    w_state_nxt = S_CALC;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_CALC: begin
                w_state_nxt = S_SHOW;
            end
            S_SHOW: begin
                if (r_enter_p) begin
                    w_state_nxt    = S_IDLE;
                    w_byte_sel_nxt = 2'd0;
                end else begin
                    w_state_nxt = S_SHOW;
                end
            end
            S_ERR: begin
                if (r_enter_p) begin
                    w_state_nxt    = S_IDLE;
                    w_byte_sel_nxt = 2'd0;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_byte_sel_nxt = 2'd0;
                w_cnt_nxt      = {CNT_W{1'b0}};
            end
        endcase
    end

    // Moore output decode of the next state; the register stage below makes
    // the ports change together with the state they describe.
    always_comb begin
        w_loaddata_nxt     = 1'b0;
        w_load_a_nxt       = 1'b0;
        w_load_b_nxt       = 1'b0;
        w_latch_result_nxt = 1'b0;
        w_disp_sel_nxt     = 2'd0;
        w_busy_nxt         = 1'b0;
        w_done_nxt         = 1'b0;
        w_error_nxt        = 1'b0;
        case (w_state_nxt)
            S_IDLE, S_WAIT_A: begin
                w_load_a_nxt = 1'b1;
            end
            S_STROBE_A: begin
                w_load_a_nxt   = 1'b1;
                w_loaddata_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
            end
            S_ACK_A: begin
                w_load_a_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
            end
            S_WAIT_B: begin
                w_load_b_nxt   = 1'b1;
                w_disp_sel_nxt = 2'd1;
            end
            S_STROBE_B: begin
                w_load_b_nxt   = 1'b1;
                w_loaddata_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
                w_disp_sel_nxt = 2'd1;
            end
            S_ACK_B: begin
                w_load_b_nxt   = 1'b1;
                w_busy_nxt     = 1'b1;
                w_disp_sel_nxt = 2'd1;
            end
            S_SETTLE: begin
                w_busy_nxt     = 1'b1;
                w_disp_sel_nxt = 2'd1;
            end
            S_CALC: begin
                w_latch_result_nxt = 1'b1;
                w_disp_sel_nxt     = 2'd1;
            end
            S_SHOW: begin
                w_done_nxt     = 1'b1;
                w_disp_sel_nxt = 2'd2;
            end
            S_ERR: begin
                w_error_nxt    = 1'b1;
                w_disp_sel_nxt = 2'd3;
            end
            default: begin
                w_disp_sel_nxt = 2'd0;
            end
        endcase
    end

    // State register, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_byte_sel     <= 2'd0;
            r_cnt          <= {CNT_W{1'b0}};
            r_loaddata     <= 1'b0;
            r_load_a       <= 1'b0;
            r_load_b       <= 1'b0;
            r_latch_result <= 1'b0;
            r_disp_sel     <= 2'd0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_byte_sel     <= w_byte_sel_nxt;
            r_cnt          <= w_cnt_nxt;
            r_loaddata     <= w_loaddata_nxt;
            r_load_a       <= w_load_a_nxt;
            r_load_b       <= w_load_b_nxt;
            r_latch_result <= w_latch_result_nxt;
            r_disp_sel     <= w_disp_sel_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_error        <= w_error_nxt;
        end
    end

    assign loaddata     = r_loaddata;
    assign load_a       = r_load_a;
    assign load_b       = r_load_b;
    assign byte_sel     = r_byte_sel;
    assign latch_result = r_latch_result;
    assign disp_sel     = r_disp_sel;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;

endmodule

// File: doc/adder_control_unit.md
Name: adder_control_unit

Overview:
- FSM controller that sequences the 32-bit adder datapath from the board switches and the enter key.
- Collects operand A, then operand B, one byte per enter press, least-significant byte first.
- Strobes each byte into the peripherals unit with a loaddata/ready handshake, waits for the adder to settle, latches the result and selects the value shown on the displays.
- Sits beside datapathunit in the top level and drives its loaddata input.

Parameters:
- BYTES_PER_OPERAND, 4, bytes collected per operand (1..4); byte_sel counts 0..BYTES_PER_OPERAND-1.
- ACK_TIMEOUT, 16, maximum cycles to wait for inputdata_ready after a loaddata strobe.
- SETTLE_CYCLES, 2, cycles between the last B byte being acknowledged and the latch_result pulse.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enter  input  1  raw enter key, active-high, asynchronous to clk.
- inputdata_ready  input  1  datapath acknowledge: the byte was accepted.
- loaddata  output  1  one-cycle strobe: load inputdata into the byte/operand selected below.
- load_a  output  1  high while collecting operand A.
- load_b  output  1  high while collecting operand B.
- byte_sel  output  2  index of the byte being loaded.
- latch_result  output  1  one-cycle pulse: capture dataR.
- disp_sel  output  2  display source: 0 = A, 1 = B, 2 = R, 3 = error pattern.
- busy  output  1  high while a handshake or settle is in progress.
- done  output  1  high in SHOW.
- error  output  1  high in ERR.

Behaviour:
- **Reset** (reset = 0, asynchronous):
  - state = IDLE.
  - loaddata = latch_result = busy = done = error = 0.
  - load_a = load_b = 0, byte_sel = 0, disp_sel = 0.
  - Synchronizer and edge-detect flops cleared.
  - Reset mid-handshake or mid-settle aborts immediately. No partial state survives.
- **Enter input:**
  - 2-flop synchronizer, then rising-edge detect, giving a one-cycle enter_p.
  - enter_p is high 3 clk edges after the raw rising edge.
  - A held key produces exactly one enter_p.
  - enter_p is ignored in every state except IDLE, WAIT_A, WAIT_B, SHOW and ERR.
- **States:**
  - IDLE:
    - Outputs: disp_sel = 0, load_a = 1.
    - enter_p -> STROBE_A with byte_sel = 0.
    - The first press loads byte 0.
  - WAIT_A:
    - Outputs: load_a = 1, disp_sel = 0.
    - enter_p -> STROBE_A.
  - STROBE_A:
    - Outputs: loaddata = 1 for exactly one cycle, busy = 1.
    - Next state: ACK_A.
  - ACK_A:
    - Outputs: busy = 1. A timeout counter counts each cycle.
    - inputdata_ready = 1: if byte_sel = BYTES_PER_OPERAND-1, go to WAIT_B with byte_sel = 0. Otherwise byte_sel += 1 and go to WAIT_A.
    - Counter reaches ACK_TIMEOUT without ready -> ERR.
    - Ready seen in the same cycle as the timeout terminal count counts as accepted; ready has priority.
  - WAIT_B, STROBE_B, ACK_B:
    - Same as the A states, with load_b = 1 and disp_sel = 1.
    - On the final B byte acknowledged -> SETTLE.
  - SETTLE:
    - Outputs: busy = 1.
    - Counts SETTLE_CYCLES, then -> CALC.
  - CALC:
    - Outputs: latch_result = 1 for one cycle.
    - Next state: SHOW.
  - SHOW:
    - Outputs: done = 1, disp_sel = 2.
    - enter_p -> IDLE, with byte_sel = 0.
  - ERR:
    - Outputs: error = 1, disp_sel = 3.
    - enter_p -> IDLE.
- **Handshake and widths:**
  - loaddata is never reasserted before the ack or timeout of the previous strobe.
  - inputdata_ready outside ACK_x is ignored.
  - byte_sel never exceeds BYTES_PER_OPERAND-1. With BYTES_PER_OPERAND = 1 it stays 0.
  - Total loaddata pulses per complete operation = 2*BYTES_PER_OPERAND.
  - All outputs are registered, i.e. Moore outputs from the state register.

Test Plan:
- **Full sequence:** after reset, 8 enter presses with ready returned 1 cycle after each loaddata.
  - Required: 8 loaddata pulses.
  - byte_sel sequence 0,1,2,3 with load_a = 1, then 0,1,2,3 with load_b = 1.
  - latch_result exactly SETTLE_CYCLES+1 cycles after the 8th ack; done = 1, disp_sel = 2.
- **Held key:** enter held 50 cycles in WAIT_A.
  - Required: exactly one loaddata; byte_sel advances by 1 only.
- **Timeout:** ready held 0 after a strobe.
  - Required: error = 1 and disp_sel = 3 exactly ACK_TIMEOUT cycles after loaddata.
  - The next enter press returns to IDLE with error = 0.
- **Ready priority at terminal count:** ready arrives on the terminal-count cycle.
  - Required: no error; byte_sel increments.
- **Reset during SETTLE:** reset = 0 asserted while in SETTLE.
  - Required: outputs reach their reset values without waiting for a clk edge.
  - After release, the first enter press strobes A byte 0.
- **Stray and restart:** inputdata_ready pulses in WAIT_A; a press in SHOW.
  - Required: stray ready is ignored and byte_sel is unchanged.
  - The press in SHOW gives disp_sel = 0 and load_a = 1 in IDLE.
